dmem_lsu: RTL and testbench

//  Load/store unit between CPU execute stage and a word-wide synchronous data RAM.

---
 rtl/dmem_lsu_pkg.sv | 31 +++
 rtl/barrelsft32.sv | 34 +++
 rtl/dmem_align.sv | 54 +++++
 rtl/dmem_lsu.sv | 128 ++++++++++++
 tb/tb_dmem_lsu.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: op encodings,
// FSM state encoding and the illegal-op decode.
// Imported by dmem_align and dmem_lsu.
package dmem_lsu_pkg;

   // Request op encodings (stores look at the size field [1:0] only)
   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   // Size field op[1:0]
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_RDW  = 3'd2,
      ST_WR   = 3'd3,
      ST_RSP  = 3'd4
   } state_e;

   // 011, 110 and 111 have no meaning for loads or stores
   function automatic logic op_illegal(input logic [2:0] op);
      return (op == 3'b011) || (op[2:1] == 2'b11);
   endfunction

endpackage

// File: rtl/barrelsft32.sv
// Purpose: 32-bit combinational barrel shifter, left / logical right / arithmetic right.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: i_din data, i_shamt shift amount, i_left 1=shift left,
//        i_arith 1=sign fill on right shift, o_dout result.
module barrelsft32 (
   input  logic [31:0] i_din,
   input  logic [4:0]  i_shamt,
   input  logic        i_left,
   input  logic        i_arith,
   output logic [31:0] o_dout
);

   logic        w_fill;
   logic [31:0] w_s0, w_s1, w_s2, w_s3, w_s4, w_s5;

   // A left shift is a right shift of the bit-reversed word, so one
   // right-shifting log ladder serves both directions.
   always_comb begin
      w_fill = i_arith & ~i_left & i_din[31];
      for (int i = 0; i < 32; i++) begin
         w_s0[i] = i_left ? i_din[31-i] : i_din[i];
      end
      w_s1 = i_shamt[0] ? {w_fill,        w_s0[31:1]}  : w_s0;
      w_s2 = i_shamt[1] ? {{2{w_fill}},   w_s1[31:2]}  : w_s1;
      w_s3 = i_shamt[2] ? {{4{w_fill}},   w_s2[31:4]}  : w_s2;
      w_s4 = i_shamt[3] ? {{8{w_fill}},   w_s3[31:8]}  : w_s3;
      w_s5 = i_shamt[4] ? {{16{w_fill}},  w_s4[31:16]} : w_s4;
      for (int i = 0; i < 32; i++) begin
         o_dout[i] = i_left ? w_s5[31-i] : w_s5[i];
      end
   end

endmodule

// File: rtl/dmem_align.sv
// Purpose: load-data alignment/extension and sub-word store merge.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: i_rdata RAM word, i_wdata LSB-aligned store data, i_off byte offset,
//        i_op request op, o_load_data extended load result, o_merged RMW word.
module dmem_align
   import dmem_lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_op,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merged
);

   logic        w_half;
   logic [1:0]  w_lsh_lanes;
   logic [4:0]  w_rsh;
   logic [4:0]  w_off_sh;
   logic [31:0] w_ld_l, w_ld_r, w_wd_sh, w_mask_base, w_mask;

   assign w_half      = (i_op[1:0] == SZ_H);
   // Push the wanted lane(s) to the top, then shift back down with the
   // chosen fill: left by 4-off-size lanes, right by 4-size lanes.
   assign w_lsh_lanes = w_half ? (2'd2 - i_off) : (2'd3 - i_off);
   assign w_rsh       = w_half ? 5'd16 : 5'd24;
   assign w_off_sh    = {i_off, 3'b000};
   assign w_mask_base = w_half ? 32'h0000_FFFF : 32'h0000_00FF;

   barrelsft32 u_ld_left (
      .i_din(i_rdata), .i_shamt({w_lsh_lanes, 3'b000}),
      .i_left(1'b1), .i_arith(1'b0), .o_dout(w_ld_l)
   );

   barrelsft32 u_ld_right (
      .i_din(w_ld_l), .i_shamt(w_rsh),
      .i_left(1'b0), .i_arith(~i_op[2]), .o_dout(w_ld_r)
   );

   barrelsft32 u_wd_left (
      .i_din(i_wdata), .i_shamt(w_off_sh),
      .i_left(1'b1), .i_arith(1'b0), .o_dout(w_wd_sh)
   );

   barrelsft32 u_mask_left (
      .i_din(w_mask_base), .i_shamt(w_off_sh),
      .i_left(1'b1), .i_arith(1'b0), .o_dout(w_mask)
   );

   assign o_load_data = (i_op[1:0] == SZ_W) ? i_rdata : w_ld_r;
   assign o_merged    = (i_rdata & ~w_mask) | (w_wd_sh & w_mask);

endmodule

// File: rtl/dmem_lsu.sv
// Purpose: byte/half/word load-store unit in front of a word-wide synchronous RAM.
// Latency: accept edge to rsp_valid: error 1, SW 2, load 3, SB/SH 4 cycles.
// Backpressure: one request in flight; req_ready only in IDLE, rsp held until rsp_ready.
// Ports: req_* request (valid/ready), rsp_* response (valid/ready),
//        mem_* synchronous RAM port (read data valid the cycle after mem_re).
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_op,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   state_e        r_state, w_state_nxt;
   logic [AW+1:0] r_addr;
   logic [2:0]    r_op;
   logic          r_we;
   logic [31:0]   r_wdata, r_merge, r_rdata;
   logic          r_err;

   logic          w_misalign, w_range, w_req_err, w_req_sw;
   logic [31:0]   w_load_data, w_merged;

   assign w_misalign = ((req_op[1:0] == SZ_H) && req_addr[0]) ||
                       ((req_op[1:0] == SZ_W) && (req_addr[1:0] != 2'b00));
   assign w_range    = |req_addr[31:AW+2];
   assign w_req_err  = w_misalign | w_range | op_illegal(req_op);
   assign w_req_sw   = req_we && (req_op[1:0] == SZ_W);

   dmem_align u_align (
      .i_rdata     (mem_rdata),
      .i_wdata     (r_wdata),
      .i_off       (r_addr[1:0]),
      .i_op        (r_op),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );

   // RAM strobes come from state only, so a reset mid-RMW kills mem_we at once.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      mem_wdata   = 32'h0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_req_err)     w_state_nxt = ST_RSP;
               else if (w_req_sw) w_state_nxt = ST_WR;
               else               w_state_nxt = ST_RD;
            end
         end
         ST_RD: begin
            mem_re      = 1'b1;
            w_state_nxt = ST_RDW;
         end
         ST_RDW: begin
            w_state_nxt = r_we ? ST_WR : ST_RSP;
         end
         ST_WR: begin
            mem_we      = 1'b1;
            mem_wdata   = (r_op[1:0] == SZ_W) ? r_wdata : r_merge;
            w_state_nxt = ST_RSP;
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign mem_addr  = r_addr[AW+1:2];
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_op    <= 3'b000;
         r_we    <= 1'b0;
         r_wdata <= 32'h0;
         r_merge <= 32'h0;
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_addr  <= req_addr[AW+1:0];
                  r_op    <= req_op;
                  r_we    <= req_we;
                  r_wdata <= req_wdata;
                  r_err   <= w_req_err;
                  r_rdata <= 32'h0;
               end
            end
            ST_RDW: begin
               if (r_we) r_merge <= w_merged;
               else      r_rdata <= w_load_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural synchronous RAM model.
// Latency is counted from the accepting edge (sample after that edge = 1).
// All expected values are hand-computed constants.
module tb_dmem_lsu;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [2:0]    req_op = 3'b000;
   logic [31:0]   req_addr = 32'h0;
   logic [31:0]   req_wdata = 32'h0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] mem_addr;
   logic          mem_re;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic [31:0]   ram [0:(1<<AW)-1];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [31:0]   pl_dat = 32'h0;
   int            rd_cnt = 0;
   int            wr_cnt = 0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_lsu #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous RAM model with a backdoor preload port
   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_dat;
      if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (mem_re) begin
         mem_rdata <= ram[mem_addr];
         rd_cnt <= rd_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_dat = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic err, output int nre, output int nwe);
      int re0, we0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
      re0 = rd_cnt; we0 = wr_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = rsp_rdata; err = rsp_err;
      nre = rd_cnt - re0; nwe = wr_cnt - we0;
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   // Load table on RAM[1] = 0x8844_2211
   logic [2:0]  ld_op  [7] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001};
   logic [31:0] ld_adr [7] = '{32'h5, 32'h7, 32'h7, 32'h6, 32'h6, 32'h4, 32'h4};
   logic [31:0] ld_exp [7] = '{32'h0000_0022, 32'hFFFF_FF88, 32'h0000_0088,
                              32'hFFFF_8844, 32'h0000_8844, 32'h8844_2211,
                              32'h0000_2211};
   // Rejected requests
   logic [2:0]  er_op  [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
   logic [31:0] er_adr [4] = '{32'h3, 32'h2, 32'h0, 32'h1000};

   initial begin
      int          lat, nre, nwe, n;
      logic [31:0] rd;
      logic        err;

      preload(10'd0, 32'h0000_0000);
      preload(10'd1, 32'h8844_2211);
      preload(10'd2, 32'h0000_0000);
      preload(10'd3, 32'h1122_3344);

      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err",   {31'b0, rsp_err}, 32'h0);
      chk("rst_mem_re",    {31'b0, mem_re}, 32'h0);
      chk("rst_mem_we",    {31'b0, mem_we}, 32'h0);
      chk("rst_mem_addr",  {22'b0, mem_addr}, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         do_req(1'b0, ld_op[i], ld_adr[i], 32'h0, lat, rd, err, nre, nwe);
         chk($sformatf("ld%0d_rdata", i), rd, ld_exp[i]);
         chk($sformatf("ld%0d_err", i), {31'b0, err}, 32'h0);
         chk($sformatf("ld%0d_lat", i), 32'(lat), 32'd3);
         chk($sformatf("ld%0d_nwe", i), 32'(nwe), 32'd0);
         release_rsp();
      end

      do_req(1'b1, 3'b000, 32'h6, 32'h0000_00AB, lat, rd, err, nre, nwe);
      chk("sb_lat",   32'(lat), 32'd4);
      chk("sb_nre",   32'(nre), 32'd1);
      chk("sb_nwe",   32'(nwe), 32'd1);
      chk("sb_err",   {31'b0, err}, 32'h0);
      chk("sb_rdata", rd, 32'h0);
      chk("sb_ram1",  ram[1], 32'h88AB_2211);
      release_rsp();

      do_req(1'b1, 3'b001, 32'h6, 32'h0000_1234, lat, rd, err, nre, nwe);
      chk("sh_lat",  32'(lat), 32'd4);
      chk("sh_ram1", ram[1], 32'h1234_2211);
      release_rsp();

      do_req(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, lat, rd, err, nre, nwe);
      chk("sw_lat",   32'(lat), 32'd2);
      chk("sw_nre",   32'(nre), 32'd0);
      chk("sw_nwe",   32'(nwe), 32'd1);
      chk("sw_rdata", rd, 32'h0);
      chk("sw_ram2",  ram[2], 32'hDEAD_BEEF);
      release_rsp();

      do_req(1'b0, 3'b010, 32'h8, 32'h0, lat, rd, err, nre, nwe);
      chk("lw8_rdata", rd, 32'hDEAD_BEEF);
      release_rsp();

      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, er_op[i], er_adr[i], 32'h0, lat, rd, err, nre, nwe);
         chk($sformatf("er%0d_err", i), {31'b0, err}, 32'h1);
         chk($sformatf("er%0d_lat", i), 32'(lat), 32'd1);
         chk($sformatf("er%0d_nre", i), 32'(nre), 32'd0);
         chk($sformatf("er%0d_nwe", i), 32'(nwe), 32'd0);
         chk($sformatf("er%0d_rdata", i), rd, 32'h0);
         release_rsp();
      end

      // Response held under backpressure
      do_req(1'b0, 3'b010, 32'hC, 32'h0, lat, rd, err, nre, nwe);
      chk("hold_lat", 32'(lat), 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk($sformatf("hold%0d_valid", i), {31'b0, rsp_valid}, 32'h1);
         chk($sformatf("hold%0d_rdata", i), rsp_rdata, 32'h1122_3344);
         chk($sformatf("hold%0d_ready", i), {31'b0, req_ready}, 32'h0);
      end
      release_rsp();

      // Reset while an SB sits in WR
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_op = 3'b000;
      req_addr = 32'hD; req_wdata = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!mem_we && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_wr_reached", {31'b0, mem_we}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_wr_mem_we", {31'b0, mem_we}, 32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      chk("rst_wr_ram3", ram[3], 32'h1122_3344);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {31'b0, req_ready}, 32'h1);
      chk("post_rst_valid", {31'b0, rsp_valid}, 32'h0);

      do_req(1'b0, 3'b010, 32'hC, 32'h0, lat, rd, err, nre, nwe);
      chk("post_rst_lw",  rd, 32'h1122_3344);
      chk("post_rst_lat", 32'(lat), 32'd3);
      release_rsp();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
